// File: rtl/pc_unit_pkg.sv
// Shared defaults and state encodings for the fetch-stage program counter.
package pc_unit_pkg;

  localparam int          PC_WIDTH        = 32;
  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VECTOR   = 32'h8000_0180;
  localparam int          PC_STEP         = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_redirect_buffer.sv
// One-entry holding register for a redirect target that arrives while fetch is stalled.
module pc_redirect_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             vld
);

  // Clear wins over load; a load overwrites any older entry (latest wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (clr) begin
      vld <= 1'b0;
    end else if (load) begin
      q   <= din;
      vld <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: boot cycle, stall, exc/jmp/br redirects,
// buffered redirect during stall and redirect alignment checking.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(PC_EXC_VECTOR),
  parameter int               STEP         = PC_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             exc_valid,
  input  logic             jmp_valid,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             pc_valid,
  output logic             redirect_pending,
  output logic             misalign
);

  // Low address bits that must be zero; empty mask when STEP=1.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  pc_state_e        state, state_d;
  logic [WIDTH-1:0] pc_d;
  logic             pc_valid_d, misalign_d;
  logic             buf_load, buf_clr;
  logic [WIDTH-1:0] buf_din, pend_q;
  logic             pend_vld;
  logic [WIDTH-1:0] live_tgt;

  assign pc_next          = pc + WIDTH'(STEP);
  assign redirect_pending = pend_vld;
  assign live_tgt         = jmp_valid ? jmp_target : br_target;

  pc_redirect_buffer #(.WIDTH(WIDTH)) u_buf (
    .clk  (clk),
    .rst  (rst),
    .load (buf_load),
    .clr  (buf_clr),
    .din  (buf_din),
    .q    (pend_q),
    .vld  (pend_vld)
  );

  // State, PC and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_VECTOR;
      pc_valid <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      pc_valid <= pc_valid_d;
      misalign <= misalign_d;
    end
  end

  // Next-state and redirect priority: exc > stalled capture > live jmp/br > pending > sequential.
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    pc_valid_d = pc_valid;
    misalign_d = misalign;
    buf_load   = 1'b0;
    buf_clr    = 1'b0;
    buf_din    = live_tgt;
    case (state)
      BOOT: begin
        state_d    = RUN;
        pc_valid_d = 1'b1;
      end
      RUN, HOLD: begin
        if (exc_valid) begin
          pc_d       = EXC_VECTOR;
          misalign_d = 1'b0;
          buf_clr    = 1'b1;
          state_d    = RUN;
        end else if (stall) begin
          if (jmp_valid || br_valid) begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end
        end else if (jmp_valid || br_valid) begin
          pc_d       = live_tgt & ~ALIGN_MASK;
          misalign_d = |(live_tgt & ALIGN_MASK);
          buf_clr    = 1'b1;
          state_d    = RUN;
        end else if (pend_vld) begin
          pc_d       = pend_q & ~ALIGN_MASK;
          misalign_d = |(pend_q & ALIGN_MASK);
          buf_clr    = 1'b1;
          state_d    = RUN;
        end else begin
          pc_d       = pc_next;
          misalign_d = 1'b0;
          state_d    = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised next-generation program counter for the MIPS fetch stage. It replaces the free-running pc+4 register with a PC that has:
- a configurable reset vector and step;
- a pipeline stall input;
- jump, branch and exception redirects;
- a one-entry buffer that holds a redirect arriving during a stall;
- a boot cycle and alignment checking.

It drives the instruction-memory address and supplies pc_next to the branch/link logic.

Parameters:
WIDTH, 32, PC width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded by reset
EXC_VECTOR, 32'h8000_0180, PC value loaded on exception
STEP, 4, sequential increment; power of two >= 1; ALIGN_BITS = clog2(STEP)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold the PC this cycle
exc_valid  in  1  exception redirect to EXC_VECTOR; overrides stall
jmp_valid  in  1  jump redirect request
jmp_target  in  WIDTH  jump target
br_valid  in  1  taken-branch redirect request
br_target  in  WIDTH  branch target
pc  out  WIDTH  current fetch address (registered)
pc_next  out  WIDTH  pc + STEP, combinational, modulo 2^WIDTH
pc_valid  out  1  pc is a valid fetch address (registered)
redirect_pending  out  1  a buffered redirect awaits the end of the stall (registered)
misalign  out  1  the target last loaded into pc had nonzero low ALIGN_BITS (registered)

Behaviour:
- Reset (rst=1 at a clk edge, any state): pc=RESET_VECTOR, pc_valid=0, redirect_pending=0, misalign=0, state=BOOT. Reset overrides all other inputs.
- States: BOOT, RUN, HOLD.
- BOOT: the next edge goes to RUN and sets pc_valid=1. pc stays RESET_VECTOR, so the first fetch is the reset vector. All other inputs are ignored in BOOT.
- Target selection, RUN and HOLD; priority applies at every edge:
  1. exc_valid: pc=EXC_VECTOR, clear pending, go to RUN. Applies even if stall=1.
  2. stall=1 with jmp_valid or br_valid: pc holds; the target (jmp over br) is written to the pending buffer; redirect_pending=1; state=HOLD. A newer request overwrites an older pending one (latest wins).
  3. stall=1, no request: pc, state and buffer unchanged.
  4. stall=0 with jmp_valid: pc=jmp_target. Else with br_valid: pc=br_target. Either clears pending; state=RUN. A live request beats a pending one.
  5. stall=0, pending set: pc=pending target, clear pending, go to RUN.
  6. Otherwise: pc=pc+STEP, with silent wrap at 2^WIDTH.
- Latency: a redirect presented with stall=0 appears on pc at the next edge. A buffered redirect appears at the first edge with stall=0.
- Alignment, applied to every redirect load (jmp, br, pending):
  - The low ALIGN_BITS are forced to 0 in pc.
  - misalign is set to 1 if the original target had any of those bits set, else 0.
  - Sequential and exception loads set misalign=0.
  - misalign holds while pc holds.
- When STEP=1, ALIGN_BITS=0 and misalign is constantly 0.
- pc_next is always pc+STEP, including while stalled and in BOOT.

Decomposition:
- Shared define file holds:
  - default WIDTH, RESET_VECTOR, EXC_VECTOR, STEP;
  - state encodings: BOOT=2'd0, RUN=2'd1, HOLD=2'd2.
- Sub-module pc_redirect_buffer: a one-entry target register plus valid flag, with load/overwrite/clear controls and synchronous reset.
- The top-level pc_unit contains the FSM, the priority mux, alignment and the adder.

Test Plan:
1. Reset sequence: rst=1 for 2 cycles, then 0 -> pc=0 with pc_valid=0; one edge later pc_valid=1, pc=0; next edge pc=4, then 8.
2. Sequential wrap: WIDTH=8, STEP=4, reach pc=8'hFC with no stall -> next pc=8'h00, misalign=0.
3. Live priority: jmp_valid and br_valid together with stall=0, jmp_target=0x100, br_target=0x200 -> next pc=0x100, redirect_pending=0.
4. Stalled redirect: stall=1 and br_valid with br_target=0x40 at pc=0x10 -> pc stays 0x10 and redirect_pending=1. After 3 stall cycles, drop stall -> pc=0x40, pending=0.
5. Exception over stall with pending: pending=0x40, stall=1, exc_valid=1 -> pc=0x8000_0180, pending=0. Release stall -> pc=0x8000_0184.
6. Misaligned jump, then reset mid-HOLD:
   - jmp_target=0x103 -> pc=0x100, misalign=1; next sequential edge -> pc=0x104, misalign=0.
   - Then enter HOLD and assert rst -> pc=0, pending=0, pc_valid=0.
